// File: rtl/store_buffer.sv
// Posted-store FIFO in front of a single-port byte-addressed data memory.
// Loads get the port first and stall on overlap with pending stores; define STORE_BUF_FWD_EN to forward exact matches.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_ctrl,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_ctrl,
  output logic [31:0] ld_data,
  output logic        ld_stall,
  output logic        empty,
  output logic [31:0] Address,
  output logic [31:0] DataWr,
  output logic        DMWr,
  output logic [2:0]  DMCtrl,
  input  logic [31:0] DataRd
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] head, tail, idx;
  logic [PW:0]   count;
  logic [31:0]   e_addr [DEPTH];
  logic [31:0]   e_data [DEPTH];
  logic [2:0]    e_ctrl [DEPTH];
  logic [32:0]   ld_end;
  logic          hazard, fwd, mem_ld, drain, wr;

  // Exclusive end of the byte range; 33 bits so ranges near 2^32 never wrap.
  function automatic logic [32:0] span_end(input logic [31:0] a, input logic [2:0] c);
    case (c[1:0])
      2'b00:   span_end = {1'b0, a} + 33'd1;
      2'b01:   span_end = {1'b0, a} + 33'd2;
      default: span_end = {1'b0, a} + 33'd4;
    endcase
  endfunction

`ifdef STORE_BUF_FWD_EN
  logic        fwd_hit;
  logic [31:0] fwd_data;

  function automatic logic [31:0] ld_ext(input logic [31:0] d, input logic [2:0] c);
    case (c)
      3'b000:  ld_ext = {{24{d[7]}}, d[7:0]};
      3'b001:  ld_ext = {{16{d[15]}}, d[15:0]};
      3'b100:  ld_ext = {24'd0, d[7:0]};
      3'b101:  ld_ext = {16'd0, d[15:0]};
      default: ld_ext = d;
    endcase
  endfunction
`endif

  // Scan oldest to youngest so the last hit is the youngest overlapping entry.
  always_comb begin
    hazard = 1'b0;
    idx    = '0;
`ifdef STORE_BUF_FWD_EN
    fwd_hit  = 1'b0;
    fwd_data = '0;
`endif
    ld_end = span_end(ld_addr, ld_ctrl);
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (ld_req && k < int'(count) &&
          ({1'b0, e_addr[idx]} < ld_end) &&
          ({1'b0, ld_addr} < span_end(e_addr[idx], e_ctrl[idx]))) begin
        hazard = 1'b1;
`ifdef STORE_BUF_FWD_EN
        fwd_hit  = (e_addr[idx] == ld_addr) && (e_ctrl[idx][1:0] == ld_ctrl[1:0]);
        fwd_data = e_data[idx];
`endif
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  assign fwd = hazard && fwd_hit;
`else
  assign fwd = 1'b0;
`endif

  assign ld_stall = hazard && !fwd;
  assign mem_ld   = ld_req && !ld_stall && !fwd;
  assign st_ready = (count != (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign wr       = st_valid && st_ready && !st_ctrl[2] && (st_ctrl[1:0] != 2'b11);

  always_comb begin
    Address = '0;
    DataWr  = '0;
    DMWr    = 1'b0;
    DMCtrl  = 3'b000;
    ld_data = '0;
    drain   = 1'b0;
    if (mem_ld) begin
      Address = ld_addr;
      DMCtrl  = ld_ctrl;
      ld_data = DataRd;
    end else if (count != '0) begin
      Address = e_addr[head];
      DataWr  = e_data[head];
      DMCtrl  = e_ctrl[head];
      DMWr    = 1'b1;
      drain   = 1'b1;
    end
`ifdef STORE_BUF_FWD_EN
    if (fwd) ld_data = ld_ext(fwd_data, ld_ctrl);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_addr[i] <= '0;
        e_data[i] <= '0;
        e_ctrl[i] <= '0;
      end
    end else begin
      if (wr) begin
        e_addr[tail] <= st_addr;
        e_data[tail] <= st_data;
        e_ctrl[tail] <= st_ctrl;
        tail         <= tail + 1'b1;
      end
      if (drain) head <= head + 1'b1;
      count <= count + (PW+1)'(wr) - (PW+1)'(drain);
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed steps plus random traffic against a queue-and-memory-image model.
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, ld_req, DMWr, st_ready, ld_stall, empty;
  logic [31:0] st_addr, st_data, ld_addr, ld_data, Address, DataWr, DataRd;
  logic [2:0]  st_ctrl, ld_ctrl, DMCtrl;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_ctrl(st_ctrl),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_ctrl(ld_ctrl), .ld_data(ld_data),
    .ld_stall(ld_stall), .empty(empty), .Address(Address), .DataWr(DataWr),
    .DMWr(DMWr), .DMCtrl(DMCtrl), .DataRd(DataRd)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  c;
  } st_t;

  st_t        q[$];
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  int         n_vec = 0, n_err = 0;
  logic       obs_rdy, obs_stall, obs_wr, last_stall;
  logic [31:0] obs_ld;

  function automatic int sz(input logic [2:0] c);
    return (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] c);
    case (c)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Memory seen by the DUT: asynchronous read, byte-granular write
  always_comb DataRd = ext({mem[8'(Address+32'd3)], mem[8'(Address+32'd2)],
                            mem[8'(Address+32'd1)], mem[8'(Address)]}, DMCtrl);
  always @(posedge clk)
    if (DMWr) for (int i = 0; i < sz(DMCtrl); i++) mem[8'(Address+i)] <= DataWr[8*i +: 8];

  function automatic logic [31:0] ref_rd(input logic [31:0] a, input logic [2:0] c);
    return ext({ref_mem[8'(a+32'd3)], ref_mem[8'(a+32'd2)], ref_mem[8'(a+32'd1)], ref_mem[8'(a)]}, c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: called at posedge+1 with inputs set; checks at negedge, advances model at posedge.
  task automatic cyc();
    logic e_rdy, e_haz, e_fwd, e_stall, e_wr;
    logic [31:0] e_addr, e_wd, e_ld;
    logic [2:0]  e_ctl;
    st_t yo;
    longint la, le, ea, ee;
    yo = '{a: 0, d: 0, c: 0};
    e_rdy = (q.size() < 4);
    e_haz = 1'b0;
    e_fwd = 1'b0;
    la = longint'(ld_addr);
    le = la + sz(ld_ctrl);
    if (ld_req) foreach (q[i]) begin
      ea = longint'(q[i].a);
      ee = ea + sz(q[i].c);
      if (ea < le && la < ee) begin e_haz = 1'b1; yo = q[i]; end
    end
`ifdef STORE_BUF_FWD_EN
    e_fwd = e_haz && (yo.a == ld_addr) && (sz(yo.c) == sz(ld_ctrl));
`endif
    e_stall = e_haz && !e_fwd;
    e_wr = 1'b0; e_addr = 0; e_wd = 0; e_ctl = 0; e_ld = 0;
    if (ld_req && !e_stall && !e_fwd) begin
      e_addr = ld_addr; e_ctl = ld_ctrl; e_ld = ref_rd(ld_addr, ld_ctrl);
    end else if (q.size() != 0) begin
      e_wr = 1'b1; e_addr = q[0].a; e_wd = q[0].d; e_ctl = q[0].c;
    end
    if (e_fwd) e_ld = ext(yo.d, ld_ctrl);
    #4;
    obs_rdy = st_ready; obs_stall = ld_stall; obs_wr = DMWr; obs_ld = ld_data;
    last_stall = e_stall;
    chk("st_ready", {31'd0, st_ready}, {31'd0, e_rdy});
    chk("empty", {31'd0, empty}, {31'd0, q.size() == 0});
    chk("ld_stall", {31'd0, ld_stall}, {31'd0, e_stall});
    chk("DMWr", {31'd0, DMWr}, {31'd0, e_wr});
    chk("Address", Address, e_addr);
    chk("DataWr", DataWr, e_wd);
    chk("DMCtrl", {29'd0, DMCtrl}, {29'd0, e_ctl});
    chk("ld_data", ld_data, e_ld);
    @(posedge clk);
    if (e_wr) begin
      for (int i = 0; i < sz(q[0].c); i++) ref_mem[8'(q[0].a+i)] = q[0].d[8*i +: 8];
      void'(q.pop_front());
    end
    if (st_valid && e_rdy && (st_ctrl inside {3'b000, 3'b001, 3'b010}))
      q.push_back('{a: st_addr, d: st_data, c: st_ctrl});
    #1;
  endtask

  task automatic set_st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    st_valid = v; st_addr = a; st_data = d; st_ctrl = c;
  endtask

  task automatic set_ld(input logic r, input logic [31:0] a, input logic [2:0] c);
    ld_req = r; ld_addr = a; ld_ctrl = c;
  endtask

  initial begin
    logic [2:0] lc [5];
    int n;
    lc = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    // reset held with a store offered
    rst_n = 1'b0;
    set_st(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
    set_ld(1'b0, 32'h0, 3'b000);
    #3;
    chk("rst_ready", {31'd0, st_ready}, 32'd1);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_DMWr", {31'd0, DMWr}, 32'd0);
    chk("rst_Address", Address, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_ld_stall", {31'd0, ld_stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // first store drains the following cycle
    cyc();
    set_st(1'b0, 32'h0, 32'h0, 3'b000);
    cyc();
    chk("sw_drain_wr", {31'd0, obs_wr}, 32'd1);
    #3 chk("sw_empty_after", {31'd0, empty}, 32'd1);
    @(posedge clk); #1;

    // fill behind non-overlapping loads, then let the writes out
    set_ld(1'b1, 32'h80, 3'b010);
    for (int i = 0; i < 4; i++) begin
      set_st(1'b1, 32'(4*i), $urandom, 3'b010);
      cyc();
      chk("fill_no_wr", {31'd0, obs_wr}, 32'd0);
    end
    set_st(1'b1, 32'h30, 32'h12345678, 3'b010);
    cyc();
    chk("full_ready", {31'd0, obs_rdy}, 32'd0);
    set_ld(1'b0, 32'h0, 3'b000);
    cyc();
    chk("full_drain_ready", {31'd0, obs_rdy}, 32'd0);
    chk("full_drain_wr", {31'd0, obs_wr}, 32'd1);
    set_st(1'b0, 32'h0, 32'h0, 3'b000);
    cyc();
    chk("ready_after_drain", {31'd0, obs_rdy}, 32'd1);
    for (int i = 0; i < 4; i++) cyc();

    // RAW stall on an overlapping byte store
    set_st(1'b1, 32'h21, 32'h000000AB, 3'b000);
    cyc();
    set_st(1'b0, 32'h0, 32'h0, 3'b000);
    set_ld(1'b1, 32'h20, 3'b010);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (!last_stall) break;
      n++;
    end
    chk("raw_stall_cycles", n, 1);
    chk("raw_byte1", {24'd0, obs_ld[15:8]}, 32'h000000AB);
    set_ld(1'b0, 32'h0, 3'b000);

    // unsupported store size is accepted but dropped
    set_st(1'b1, 32'h50, 32'hCAFEF00D, 3'b011);
    cyc();
    chk("bad_ctrl_ready", {31'd0, obs_rdy}, 32'd1);
    set_st(1'b0, 32'h0, 32'h0, 3'b000);
    cyc();
    chk("bad_ctrl_no_wr", {31'd0, obs_wr}, 32'd0);

`ifdef STORE_BUF_FWD_EN
    set_st(1'b1, 32'h40, 32'h0000F00D, 3'b001);
    cyc();
    set_st(1'b0, 32'h0, 32'h0, 3'b000);
    set_ld(1'b1, 32'h40, 3'b010);
    cyc();
    chk("fwd_lw_stall", {31'd0, obs_stall}, 32'd1);
    set_ld(1'b0, 32'h0, 3'b000);
    set_st(1'b1, 32'h40, 32'h0000F00D, 3'b001);
    cyc();
    set_st(1'b0, 32'h0, 32'h0, 3'b000);
    set_ld(1'b1, 32'h40, 3'b001);
    cyc();
    chk("fwd_lh_stall", {31'd0, obs_stall}, 32'd0);
    chk("fwd_lh_data", obs_ld, 32'hFFFFF00D);
    chk("fwd_lh_wr", {31'd0, obs_wr}, 32'd1);
    set_ld(1'b0, 32'h0, 3'b000);
`endif

    // reset while stores are pending discards them
    set_ld(1'b1, 32'hC0, 3'b010);
    for (int i = 0; i < 3; i++) begin
      set_st(1'b1, 32'(8*i), $urandom, 3'b010);
      cyc();
    end
    set_st(1'b0, 32'h0, 32'h0, 3'b000);
    set_ld(1'b0, 32'h0, 3'b000);
    rst_n = 1'b0;
    #3;
    chk("midrst_DMWr", {31'd0, DMWr}, 32'd0);
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // random traffic with dense address overlap
    for (int i = 0; i < 300; i++) begin
      set_st($urandom_range(0, 2) != 0, 32'($urandom_range(0, 63)), $urandom,
             ($urandom_range(0, 9) == 0) ? 3'b011 : 3'($urandom_range(0, 2)));
      set_ld($urandom_range(0, 1) == 1, 32'($urandom_range(0, 63)), lc[$urandom_range(0, 4)]);
      cyc();
    end
    set_st(1'b0, 32'h0, 32'h0, 3'b000);
    set_ld(1'b0, 32'h0, 3'b000);
    for (int i = 0; i < 6; i++) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
